// File: rtl/pc_ctrl.sv
// pc_ctrl: front-end sequencing controller for the program counter.
// Picks one redirect among trap / EX branch-jalr / ID jal / a deferred
// redirect, and merges the fetch, divider and load-use hold sources into the
// PC's jump/jump_addr/nop controls plus IF/ID and ID/EX flush/stall strobes.
// All controls are combinational from the registered state and the inputs so
// the PC can form next-PC in the same cycle.
// Optional feature: define PC_CTRL_PERF_EN to get saturating stall and
// redirect counters; otherwise perf_stall_cnt/perf_redir_cnt read as zero.
module pc_ctrl #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ibus_wait,
    input  logic            div_busy,
    input  logic            ld_hazard,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_addr,
    input  logic            ex_jump,
    input  logic [XLEN-1:0] ex_addr,
    input  logic            id_jump,
    input  logic [XLEN-1:0] id_addr,
    output logic            jump,
    output logic [XLEN-1:0] jump_addr,
    output logic            nop,
    output logic            stall_id,
    output logic            flush_if,
    output logic            flush_id,
    output logic            trap_ack,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_redir_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_DIVW = 2'd2
    } state_t;

    // Encoded so that a larger value means a higher-priority redirect.
    typedef enum logic [1:0] {
        RK_NONE = 2'd0,
        RK_ID   = 2'd1,
        RK_EX   = 2'd2,
        RK_TRAP = 2'd3
    } kind_t;

    state_t          state_r;
    kind_t           pend_kind_r;
    logic [XLEN-1:0] pend_addr_r;

    kind_t           new_kind_s;
    logic [XLEN-1:0] new_addr_s;
    kind_t           eff_kind_s;
    logic [XLEN-1:0] eff_addr_s;

    logic            jump_s;
    logic [XLEN-1:0] jump_addr_s;
    logic            nop_s;
    logic            stall_id_s;
    logic            flush_if_s;
    logic            flush_id_s;
    logic            trap_ack_s;

    // Highest-priority redirect requested by the sources this cycle.
    always_comb begin
        if (trap_req) begin
            new_kind_s = RK_TRAP;
            new_addr_s = trap_addr;
        end else if (ex_jump) begin
            new_kind_s = RK_EX;
            new_addr_s = ex_addr;
        end else if (id_jump) begin
            new_kind_s = RK_ID;
            new_addr_s = id_addr;
        end else begin
            new_kind_s = RK_NONE;
            new_addr_s = RESET_ADDR;
        end
    end

    // Merge with the deferred redirect: a new request only replaces it when
    // strictly higher in priority. In DIVW every request is ignored.
    always_comb begin
        if (state_r == ST_DIVW) begin
            eff_kind_s = RK_NONE;
            eff_addr_s = RESET_ADDR;
        end else if ((state_r == ST_PEND) && (new_kind_s <= pend_kind_r)) begin
            eff_kind_s = pend_kind_r;
            eff_addr_s = pend_addr_r;
        end else begin
            eff_kind_s = new_kind_s;
            eff_addr_s = new_addr_s;
        end
    end

    // PC and pipeline controls for the current cycle.
    always_comb begin
        jump_s      = 1'b0;
        jump_addr_s = RESET_ADDR;
        nop_s       = 1'b0;
        stall_id_s  = 1'b0;
        flush_if_s  = 1'b0;
        flush_id_s  = 1'b0;
        trap_ack_s  = 1'b0;
        if (rst) begin
            nop_s = 1'b1;
        end else if (state_r == ST_DIVW) begin
            // On the exit cycle the divider is free; only fetch/load-use holds apply.
            if (div_busy || ld_hazard || ibus_wait) begin
                nop_s      = 1'b1;
                stall_id_s = 1'b1;
                flush_id_s = ld_hazard & ~div_busy;
            end else begin
                nop_s = 1'b0;
            end
        end else if (eff_kind_s != RK_NONE) begin
            if (ibus_wait) begin
                nop_s = 1'b1;
            end else begin
                jump_s      = 1'b1;
                jump_addr_s = eff_addr_s;
                flush_if_s  = 1'b1;
                flush_id_s  = (eff_kind_s == RK_TRAP) || (eff_kind_s == RK_EX);
                trap_ack_s  = (eff_kind_s == RK_TRAP);
            end
        end else if (div_busy || ld_hazard || ibus_wait) begin
            nop_s      = 1'b1;
            stall_id_s = 1'b1;
            flush_id_s = ld_hazard & ~div_busy;
        end else begin
            nop_s = 1'b0;
        end
    end

    // Sequencing state and the deferred-redirect register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            pend_kind_r <= RK_NONE;
            pend_addr_r <= RESET_ADDR;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if ((eff_kind_s != RK_NONE) && ibus_wait) begin
                        state_r     <= ST_PEND;
                        pend_kind_r <= eff_kind_s;
                        pend_addr_r <= eff_addr_s;
                    end else if ((eff_kind_s == RK_NONE) && div_busy) begin
                        state_r <= ST_DIVW;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PEND: begin
                    if (ibus_wait) begin
                        pend_kind_r <= eff_kind_s;
                        pend_addr_r <= eff_addr_s;
                    end else begin
                        state_r     <= ST_RUN;
                        pend_kind_r <= RK_NONE;
                        pend_addr_r <= RESET_ADDR;
                    end
                end
                ST_DIVW: begin
                    if (!div_busy) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_DIVW;
                    end
                end
                default: begin
                    state_r     <= ST_RUN;
                    pend_kind_r <= RK_NONE;
                    pend_addr_r <= RESET_ADDR;
                end
            endcase
        end
    end

`ifdef PC_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] redir_cnt_r;

    // Saturating counters of held-PC cycles and issued redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            redir_cnt_r <= 32'd0;
        end else begin
            if (nop_s && !jump_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (jump_s && (redir_cnt_r != 32'hFFFF_FFFF)) begin
                redir_cnt_r <= redir_cnt_r + 32'd1;
            end else begin
                redir_cnt_r <= redir_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
    assign perf_redir_cnt = redir_cnt_r;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_redir_cnt = 32'd0;
`endif

    assign jump      = jump_s;
    assign jump_addr = jump_addr_s;
    assign nop       = nop_s;
    assign stall_id  = stall_id_s;
    assign flush_if  = flush_if_s;
    assign flush_id  = flush_id_s;
    assign trap_ack  = trap_ack_s;

endmodule
